// File: rtl/system_workers_cpu_1_cpu_mul_combine.sv
// Multiplier combine stages A and W.
// Stage A registers the low partial product and the folded cross sum. Stage W forms the low
// 32 bits of the 32x32 product. A sticky flag reports when a live A entry is overwritten
// while W is stalled.
module system_workers_cpu_1_cpu_mul_combine #(
  parameter int unsigned CHECK_OVERRUN = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] M_mul_cell_p1,
  input  logic [31:0] M_mul_cell_p2,
  input  logic [31:0] M_mul_cell_p3,
  input  logic        M_mul_go,
  input  logic        A_en,
  input  logic        W_en,
  input  logic        A_pipe_flush,
  output logic [31:0] W_mul_result,
  output logic        W_mul_valid,
  output logic        A_mul_pending,
  output logic        mul_overrun
);

  logic [31:0] r_a_p1;
  logic [15:0] r_a_cross;
  logic        r_a_valid;
  logic [31:0] r_w_result;
  logic        r_w_valid;
  logic        r_overrun;

  logic [15:0] w_cross;
  logic [31:0] w_sum;
  logic        w_overrun_hit;
  logic        w_unused;

  // Only the low halves of the cross products reach the low 32 bits of the product.
  assign w_cross  = M_mul_cell_p2[15:0] + M_mul_cell_p3[15:0];
  assign w_sum    = r_a_p1 + {r_a_cross, 16'h0000};
  assign w_unused = ^{M_mul_cell_p2[31:16], M_mul_cell_p3[31:16]};

  // A live A entry is about to be replaced while W cannot take it.
  assign w_overrun_hit = (CHECK_OVERRUN != 0) && A_en && !W_en && r_a_valid;

  // Stage A: load on A_en; flush kills the valid bit even while A is stalled.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_a_p1    <= 32'h0;
      r_a_cross <= 16'h0;
      r_a_valid <= 1'b0;
    end else if (A_en) begin
      r_a_p1    <= M_mul_cell_p1;
      r_a_cross <= w_cross;
      r_a_valid <= M_mul_go & ~A_pipe_flush;
    end else if (A_pipe_flush) begin
      r_a_valid <= 1'b0;
    end
  end

  // Stage W: bubbles pass the valid bit but leave the last result in place.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_w_result <= 32'h0;
      r_w_valid  <= 1'b0;
    end else if (W_en) begin
      r_w_valid <= r_a_valid;
      if (r_a_valid) begin
        r_w_result <= w_sum;
      end
    end
  end

  // Sticky overrun flag, cleared only by reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_overrun <= 1'b0;
    end else if (w_overrun_hit) begin
      r_overrun <= 1'b1;
    end
  end

  assign W_mul_result  = r_w_result;
  assign W_mul_valid   = r_w_valid;
  assign A_mul_pending = r_a_valid;
  assign mul_overrun   = r_overrun;

endmodule

// File: tb/tb_system_workers_cpu_1_cpu_mul_combine.sv
// Directed bench for the multiplier combine stages.
module tb_system_workers_cpu_1_cpu_mul_combine;

  logic        clk;
  logic        reset_n;
  logic [31:0] p1, p2, p3;
  logic        go, a_en, w_en, flush;
  logic [31:0] W_mul_result;
  logic        W_mul_valid;
  logic        A_mul_pending;
  logic        mul_overrun;

  int total;
  int bad;

  system_workers_cpu_1_cpu_mul_combine #(
    .CHECK_OVERRUN(1)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .M_mul_cell_p1(p1),
    .M_mul_cell_p2(p2),
    .M_mul_cell_p3(p3),
    .M_mul_go     (go),
    .A_en         (a_en),
    .W_en         (w_en),
    .A_pipe_flush (flush),
    .W_mul_result (W_mul_result),
    .W_mul_valid  (W_mul_valid),
    .A_mul_pending(A_mul_pending),
    .mul_overrun  (mul_overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One rising edge, then settle before sampling or driving.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c,
                       input logic g, input logic ae, input logic we, input logic fl);
    p1 = a; p2 = b; p3 = c; go = g; a_en = ae; w_en = we; flush = fl;
  endtask

  task automatic test_reset();
    drive(32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    reset_n = 1'b0;
    step();
    step();
    total++;
    if ({W_mul_result, W_mul_valid, A_mul_pending, mul_overrun} !== 35'h0) begin
      bad++;
      $display("FAIL reset_outputs got=%h/%b/%b/%b exp=0/0/0/0",
               W_mul_result, W_mul_valid, A_mul_pending, mul_overrun);
    end
    reset_n = 1'b1;
    step();
  endtask

  task automatic test_basic();
    drive(32'h0000_0008, 32'h0000_000A, 32'h0000_000C, 1'b1, 1'b1, 1'b1, 1'b0);
    step();
    total++;
    if (A_mul_pending !== 1'b1 || W_mul_valid !== 1'b0) begin
      bad++;
      $display("FAIL basic_latency1 got=pend%b/val%b exp=pend1/val0", A_mul_pending, W_mul_valid);
    end
    drive(32'h0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b0);
    step();
    total++;
    if (W_mul_result !== 32'h0016_0008 || W_mul_valid !== 1'b1) begin
      bad++;
      $display("FAIL basic_result got=%h/%b exp=00160008/1", W_mul_result, W_mul_valid);
    end
  endtask

  task automatic test_wrap();
    drive(32'hFFFE_0001, 32'hFFFE_0001, 32'hFFFE_0001, 1'b1, 1'b1, 1'b1, 1'b0);
    step();
    drive(32'h0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b0);
    step();
    total++;
    if (W_mul_result !== 32'h0000_0001 || W_mul_valid !== 1'b1) begin
      bad++;
      $display("FAIL wrap_result got=%h/%b exp=00000001/1", W_mul_result, W_mul_valid);
    end
    // A bubble leaves the result alone and drops valid.
    step();
    total++;
    if (W_mul_result !== 32'h0000_0001 || W_mul_valid !== 1'b0) begin
      bad++;
      $display("FAIL bubble_hold got=%h/%b exp=00000001/0", W_mul_result, W_mul_valid);
    end
  endtask

  task automatic test_back_to_back();
    // mul1 -> 0x00031234, mul2 -> 0x00010010 (cross 0xFFFF+0x0002 wraps to 0x0001)
    drive(32'h0000_1234, 32'h0000_0001, 32'h0000_0002, 1'b1, 1'b1, 1'b1, 1'b0);
    step();
    drive(32'h0000_0010, 32'h0000_FFFF, 32'h0000_0002, 1'b1, 1'b1, 1'b1, 1'b0);
    step();
    total++;
    if (W_mul_result !== 32'h0003_1234 || W_mul_valid !== 1'b1 || A_mul_pending !== 1'b1) begin
      bad++;
      $display("FAIL b2b_first got=%h/%b/%b exp=00031234/1/1",
               W_mul_result, W_mul_valid, A_mul_pending);
    end
    drive(32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step();
      total++;
      if (W_mul_result !== 32'h0003_1234 || A_mul_pending !== 1'b1 || mul_overrun !== 1'b0) begin
        bad++;
        $display("FAIL b2b_stall%0d got=%h/pend%b/ovr%b exp=00031234/pend1/ovr0",
                 i, W_mul_result, A_mul_pending, mul_overrun);
      end
    end
    drive(32'h0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b0);
    step();
    total++;
    if (W_mul_result !== 32'h0001_0010 || W_mul_valid !== 1'b1 || A_mul_pending !== 1'b0) begin
      bad++;
      $display("FAIL b2b_second got=%h/%b/%b exp=00010010/1/0",
               W_mul_result, W_mul_valid, A_mul_pending);
    end
  endtask

  task automatic test_flush();
    drive(32'hDEAD_BEEF, 32'h0000_1111, 32'h0000_2222, 1'b1, 1'b1, 1'b1, 1'b1);
    step();
    total++;
    if (A_mul_pending !== 1'b0 || W_mul_valid !== 1'b0 || W_mul_result !== 32'h0001_0010) begin
      bad++;
      $display("FAIL flush_enter got=pend%b/val%b/%h exp=pend0/val0/00010010",
               A_mul_pending, W_mul_valid, W_mul_result);
    end
    // Load a live entry with W stalled, then flush it while A is stalled too.
    drive(32'h0000_0005, 32'h0, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0);
    step();
    total++;
    if (A_mul_pending !== 1'b1 || mul_overrun !== 1'b0) begin
      bad++;
      $display("FAIL flush_load got=pend%b/ovr%b exp=pend1/ovr0", A_mul_pending, mul_overrun);
    end
    drive(32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
    step();
    total++;
    if (A_mul_pending !== 1'b0) begin
      bad++;
      $display("FAIL flush_stalled got=pend%b exp=pend0", A_mul_pending);
    end
    drive(32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0);
    step();
    total++;
    if (W_mul_valid !== 1'b0 || W_mul_result !== 32'h0001_0010) begin
      bad++;
      $display("FAIL flush_drain got=%h/%b exp=00010010/0", W_mul_result, W_mul_valid);
    end
  endtask

  task automatic test_overrun_reset();
    drive(32'h0000_0007, 32'h0, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0);
    step();
    total++;
    if (mul_overrun !== 1'b0 || A_mul_pending !== 1'b1) begin
      bad++;
      $display("FAIL ovr_pre got=ovr%b/pend%b exp=ovr0/pend1", mul_overrun, A_mul_pending);
    end
    drive(32'h0000_0009, 32'h0, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0);
    step();
    total++;
    if (mul_overrun !== 1'b1) begin
      bad++;
      $display("FAIL ovr_set got=%b exp=1", mul_overrun);
    end
    // The overwriting entry still lands: it reaches W as 0x9.
    drive(32'h0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b0);
    step();
    step();
    total++;
    if (mul_overrun !== 1'b1 || W_mul_result !== 32'h0000_0009) begin
      bad++;
      $display("FAIL ovr_sticky got=ovr%b/%h exp=ovr1/00000009", mul_overrun, W_mul_result);
    end
    // Put a live entry in A, then reset mid-cycle without any clock edge.
    drive(32'h0000_0003, 32'h0, 32'h0, 1'b1, 1'b1, 1'b1, 1'b0);
    step();
    #2;
    reset_n = 1'b0;
    #1;
    total++;
    if ({W_mul_result, W_mul_valid, A_mul_pending, mul_overrun} !== 35'h0) begin
      bad++;
      $display("FAIL async_reset got=%h/%b/%b/%b exp=0/0/0/0",
               W_mul_result, W_mul_valid, A_mul_pending, mul_overrun);
    end
    #1;
    reset_n = 1'b1;
    drive(32'h0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b0);
    step();
    step();
    total++;
    if (W_mul_valid !== 1'b0 || W_mul_result !== 32'h0 || mul_overrun !== 1'b0) begin
      bad++;
      $display("FAIL post_reset got=%h/%b/ovr%b exp=0/0/ovr0",
               W_mul_result, W_mul_valid, mul_overrun);
    end
  endtask

  initial begin
    total   = 0;
    bad     = 0;
    reset_n = 1'b0;
    drive(32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    #3;
    test_reset();
    test_basic();
    test_wrap();
    test_back_to_back();
    test_flush();
    test_overrun_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
